// File: rtl/decode_exec_cond_unit.sv
// Decode, ALU execute and condition evaluation for the ARM-subset pipeline.
// The only state is the NZCV flag register; everything else is combinational.
module decode_exec_cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  ex_alu_op,
  input  logic        ex_store_cc,
  input  logic        shifter_carry,
  output logic [3:0]  id_alu_op,
  output logic [1:0]  id_am,
  output logic        id_load,
  output logic        id_mem_write,
  output logic        id_mem_e,
  output logic        id_mem_size,
  output logic        store_cc,
  output logic        id_b,
  output logic        id_bl,
  output logic        rf_e,
  output logic [31:0] alu_result,
  output logic        alu_n,
  output logic        alu_z,
  output logic        alu_c,
  output logic        alu_v,
  output logic [3:0]  flags_nzcv,
  output logic        cond_true,
  output logic        branch,
  output logic        branch_link
);

  // Returns {V, C, sum[31:0]} for x + y + cin; subtraction is done by the
  // caller passing ~operand, so C already comes out as NOT borrow.
  function automatic logic [33:0] add_flags(input logic signed [31:0] x,
                                            input logic signed [31:0] y,
                                            input logic cin);
    logic [32:0]        sum;
    logic signed [31:0] res;
    logic               ovf;
    sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    res = sum[31:0];
    ovf = ((x < 0) == (y < 0)) && ((res < 0) != (x < 0));
    return {ovf, sum[32], sum[31:0]};
  endfunction

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ID stage: instruction decode
  always_comb begin
    id_alu_op    = 4'b0000;
    id_am        = 2'b00;
    id_load      = 1'b0;
    id_mem_write = 1'b0;
    id_mem_e     = 1'b0;
    id_mem_size  = 1'b0;
    store_cc     = 1'b0;
    id_b         = 1'b0;
    id_bl        = 1'b0;
    rf_e         = 1'b0;
    if (instruction != 32'd0) begin
      if (instruction[27:26] == 2'b00) begin
        id_alu_op = instruction[24:21];
        store_cc  = instruction[20];
        if (instruction[25])      id_am = 2'b00;
        else if (!instruction[4]) id_am = 2'b11;
        else                      id_am = 2'b01;
        // TST/TEQ/CMP/CMN only produce flags
        rf_e = (instruction[24:23] != 2'b10);
      end else if (instruction[27:26] == 2'b01) begin
        id_mem_e     = 1'b1;
        id_load      = instruction[20];
        id_mem_write = ~instruction[20];
        id_mem_size  = instruction[22];
        rf_e         = instruction[20];
        id_alu_op    = instruction[23] ? 4'b0100 : 4'b0010;
        id_am        = instruction[25] ? 2'b01 : 2'b10;
      end else if (instruction[27:25] == 3'b101) begin
        id_bl     = instruction[24];
        id_b      = ~instruction[24];
        rf_e      = instruction[24];
        id_alu_op = 4'b0100;
        id_am     = 2'b00;
      end
    end
  end

  // EX stage: ALU, carry-in always from the registered C
  always_comb begin
    logic [33:0] arith;
    logic        is_arith;
    logic        cin;
    cin        = flags_nzcv[1];
    arith      = '0;
    is_arith   = 1'b1;
    alu_result = 32'd0;
    case (ex_alu_op)
      4'b0010, 4'b1010: arith = add_flags(alu_a, ~alu_b, 1'b1);
      4'b0011:          arith = add_flags(alu_b, ~alu_a, 1'b1);
      4'b0100, 4'b1011: arith = add_flags(alu_a, alu_b, 1'b0);
      4'b0101:          arith = add_flags(alu_a, alu_b, cin);
      4'b0110:          arith = add_flags(alu_a, ~alu_b, cin);
      4'b0111:          arith = add_flags(alu_b, ~alu_a, cin);
      default:          is_arith = 1'b0;
    endcase
    if (is_arith) begin
      alu_result = arith[31:0];
    end else begin
      case (ex_alu_op)
        4'b0000, 4'b1000: alu_result = alu_a & alu_b;
        4'b0001, 4'b1001: alu_result = alu_a ^ alu_b;
        4'b1100:          alu_result = alu_a | alu_b;
        4'b1101:          alu_result = alu_b;
        4'b1110:          alu_result = alu_a & ~alu_b;
        default:          alu_result = ~alu_b;
      endcase
    end
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
    alu_c = is_arith ? arith[32] : shifter_carry;
    alu_v = is_arith ? arith[33] : flags_nzcv[0];
  end

  // Flag register stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           flags_nzcv <= 4'b0000;
    else if (ex_store_cc) flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
  end

  // Condition check forwards live ALU flags from a flag-setting EX op
  always_comb begin
    logic [3:0] flag_src;
    flag_src    = ex_store_cc ? {alu_n, alu_z, alu_c, alu_v} : flags_nzcv;
    cond_true   = cond_eval(instruction[31:28], flag_src);
    branch      = cond_true & id_b;
    branch_link = cond_true & id_bl;
  end

endmodule

// File: tb/tb_decode_exec_cond_unit.sv
// Directed-vector bench for decode_exec_cond_unit with hand-computed expectations.
module tb_decode_exec_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  ex_alu_op;
  logic        ex_store_cc;
  logic        shifter_carry;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_am;
  logic        id_load, id_mem_write, id_mem_e, id_mem_size;
  logic        store_cc, id_b, id_bl, rf_e;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [3:0]  flags_nzcv;
  logic        cond_true, branch, branch_link;

  logic [7:0]  ctl;
  logic [3:0]  nzcv;
  assign ctl  = {id_load, id_mem_write, id_mem_e, id_mem_size, store_cc, id_b, id_bl, rf_e};
  assign nzcv = {alu_n, alu_z, alu_c, alu_v};

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  decode_exec_cond_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_a(alu_a), .alu_b(alu_b), .ex_alu_op(ex_alu_op),
    .ex_store_cc(ex_store_cc), .shifter_carry(shifter_carry),
    .id_alu_op(id_alu_op), .id_am(id_am), .id_load(id_load),
    .id_mem_write(id_mem_write), .id_mem_e(id_mem_e), .id_mem_size(id_mem_size),
    .store_cc(store_cc), .id_b(id_b), .id_bl(id_bl), .rf_e(rf_e),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .alu_v(alu_v), .flags_nzcv(flags_nzcv), .cond_true(cond_true),
    .branch(branch), .branch_link(branch_link)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic alu_set(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic scc);
    ex_alu_op   = op;
    alu_a       = a;
    alu_b       = b;
    ex_store_cc = scc;
  endtask

  // decode table: instruction, {load,mw,me,size,scc,b,bl,rf_e}, alu_op, am
  logic [31:0] dec_instr [9] = '{32'hE0812003, 32'hE5D12004, 32'hE5812000, 32'hE1530004,
                                 32'hE8900000, 32'hE0812113, 32'hE7112003, 32'hE3A01005,
                                 32'h0A000002};
  logic [7:0]  dec_ctl   [9] = '{8'b0000_0001, 8'b1011_0001, 8'b0110_0000, 8'b0000_1000,
                                 8'b0000_0000, 8'b0000_0001, 8'b1010_0001, 8'b0000_0001,
                                 8'b0000_0100};
  logic [3:0]  dec_op    [9] = '{4'h4, 4'h4, 4'h4, 4'hA, 4'h0, 4'h4, 4'h2, 4'hD, 4'h4};
  logic [1:0]  dec_am    [9] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

  initial begin
    logic [15:0] cc_exp;
    reset = 1'b0;
    instruction = 32'd0;
    alu_set(4'h0, 32'd0, 32'd0, 1'b0);
    shifter_carry = 1'b0;
    #1;
    check("rst_flags", flags_nzcv, 4'b0000);
    check("rst_ctl", ctl, 8'h00);
    check("rst_aluop", id_alu_op, 4'h0);
    check("rst_am", id_am, 2'b00);
    check("rst_cond", cond_true, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      instruction = dec_instr[i];
      #1;
      check($sformatf("dec_ctl_%0d", i), ctl, dec_ctl[i]);
      check($sformatf("dec_op_%0d", i), id_alu_op, dec_op[i]);
      check($sformatf("dec_am_%0d", i), id_am, dec_am[i]);
    end
    instruction = 32'hE0812003;
    #1 check("add_cond_al", cond_true, 1'b1);

    // ADD overflow
    @(negedge clk);
    instruction = 32'd0;
    alu_set(4'h4, 32'h7FFFFFFF, 32'h1, 1'b1);
    #1;
    check("add_res", alu_result, 32'h80000000);
    check("add_nzcv", nzcv, 4'b1001);
    check("add_flags_pre", flags_nzcv, 4'b0000);
    @(posedge clk); #1;
    check("add_flags_post", flags_nzcv, 4'b1001);

    // logical op: C from shifter, V held from register
    @(negedge clk);
    alu_set(4'h0, 32'hF0, 32'hFF, 1'b0);
    shifter_carry = 1'b1;
    #1;
    check("and_res", alu_result, 32'hF0);
    check("and_nzcv", nzcv, 4'b0011);

    // CMP 5,5 with forwarded flags
    @(negedge clk);
    shifter_carry = 1'b0;
    instruction = 32'h0A000002;
    alu_set(4'hA, 32'd5, 32'd5, 1'b1);
    #1;
    check("cmp_res", alu_result, 32'd0);
    check("cmp_nzcv", nzcv, 4'b0110);
    check("cmp_branch_fwd", branch, 1'b1);
    check("cmp_bl_fwd", branch_link, 1'b0);
    ex_store_cc = 1'b0;
    #1 check("cmp_branch_nofwd", branch, 1'b0);
    ex_store_cc = 1'b1;
    @(posedge clk); #1;
    check("cmp_flags_post", flags_nzcv, 4'b0110);

    @(negedge clk);
    ex_store_cc = 1'b0;
    instruction = 32'h1B000002;
    #1;
    check("blne_id_bl", id_bl, 1'b1);
    check("blne_bl", branch_link, 1'b0);
    instruction = 32'h0B000002;
    #1 check("bleq_bl", branch_link, 1'b1);

    // all condition codes against flags N0 Z1 C1 V0
    cc_exp = 16'b0110_0110_1010_0101;
    for (int cc = 0; cc < 16; cc++) begin
      instruction = {cc[3:0], 28'd0};
      #1 check($sformatf("cc_%0d", cc), cond_true, cc_exp[cc]);
    end

    // SBC with C=1
    alu_set(4'h6, 32'd10, 32'd3, 1'b0);
    #1 check("sbc_c1_res", alu_result, 32'd7);

    // clear flags, then SBC with C=0
    @(negedge clk);
    alu_set(4'h4, 32'd1, 32'd1, 1'b1);
    @(posedge clk); #1;
    check("flags_clear", flags_nzcv, 4'b0000);
    @(negedge clk);
    alu_set(4'h6, 32'd10, 32'd3, 1'b0);
    #1;
    check("sbc_c0_res", alu_result, 32'd6);
    check("sbc_c0_nzcv", nzcv, 4'b0010);
    alu_set(4'hF, 32'd0, 32'd0, 1'b0);
    #1;
    check("mvn_res", alu_result, 32'hFFFFFFFF);
    check("mvn_nzcv", nzcv, 4'b1000);
    alu_set(4'h3, 32'd3, 32'd10, 1'b0);
    #1;
    check("rsb_res", alu_result, 32'd7);
    check("rsb_nzcv", nzcv, 4'b0010);

    // async reset mid-operation
    @(negedge clk);
    alu_set(4'h4, 32'h7FFFFFFF, 32'h1, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_flags", flags_nzcv, 4'b1001);
    @(negedge clk);
    alu_set(4'h5, 32'd1, 32'd1, 1'b1);
    #1 check("adc_cin_reg", alu_result, 32'd2);
    alu_set(4'h4, 32'h7FFFFFFF, 32'h1, 1'b1);
    reset = 1'b0;
    #1 check("async_rst", flags_nzcv, 4'b0000);
    check("rst_comb_live", alu_result, 32'h80000000);
    @(posedge clk); #1;
    check("rst_hold", flags_nzcv, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_upd", flags_nzcv, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
